// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - shared operation codes, FSM states and decode helpers for the load/store sequencer
package lsu_ctrl_pkg;

    localparam logic [5:0] ALU_ADD = 6'h00;
    localparam logic [5:0] ALU_LB  = 6'h20;
    localparam logic [5:0] ALU_LH  = 6'h21;
    localparam logic [5:0] ALU_LW  = 6'h22;
    localparam logic [5:0] ALU_LBU = 6'h23;
    localparam logic [5:0] ALU_LHU = 6'h24;
    localparam logic [5:0] ALU_SB  = 6'h25;
    localparam logic [5:0] ALU_SH  = 6'h26;
    localparam logic [5:0] ALU_SW  = 6'h27;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    function automatic logic is_load(input logic [5:0] op);
        return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
               (op == ALU_LBU) || (op == ALU_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic is_half(input logic [5:0] op);
        return (op == ALU_LH) || (op == ALU_LHU) || (op == ALU_SH);
    endfunction

    function automatic logic is_word(input logic [5:0] op);
        return (op == ALU_LW) || (op == ALU_SW);
    endfunction

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] off);
        return (is_half(op) && off[0]) || (is_word(op) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane enables, store replication, load extraction/extension and alignment check
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [5:0]  alucode,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  mem_we,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] shifted;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign misalign = misaligned(alucode, off);

    // Store lanes: the addressed lanes are enabled, data is replicated so every lane sees it.
    always_comb begin
        mem_we    = 4'b0000;
        wdata_rep = 32'h0;
        case (alucode)
            ALU_SB: begin
                mem_we    = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
            end
            ALU_SH: begin
                mem_we    = 4'b0011 << off;
                wdata_rep = {2{wdata[15:0]}};
            end
            ALU_SW: begin
                mem_we    = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                mem_we    = 4'b0000;
                wdata_rep = 32'h0;
            end
        endcase
    end

    assign shifted  = mem_rdata >> {off, 3'b000};
    assign sel_byte = shifted[7:0];
    assign sel_half = shifted[15:0];

    // Load return: pick the addressed byte/half, then sign- or zero-extend.
    always_comb begin
        load_data = 32'h0;
        case (alucode)
            ALU_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
            ALU_LBU: load_data = {24'h0, sel_byte};
            ALU_LH:  load_data = {{16{sel_half[15]}}, sel_half};
            ALU_LHU: load_data = {16'h0, sel_half};
            ALU_LW:  load_data = mem_rdata;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer FSM and operand registers; LSU_TIMEOUT_EN adds an access abort counter
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  alucode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_cfg_check
        $error("lsu_ctrl: TIMEOUT_CYCLES does not fit in CNT_W bits");
    end

    lsu_state_e  state_q, state_d;
    logic [5:0]  alucode_q;
    logic [1:0]  off_q;
    logic [29:0] addr_q;
    logic [3:0]  we_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        abort;
    logic [5:0]  a_op;
    logic [1:0]  a_off;
    logic [3:0]  a_we;
    logic [31:0] a_wdata;
    logic [31:0] a_load;
    logic        a_mis;

    assign accept = req_valid && (state_q == LSU_IDLE);

    // In IDLE the aligner looks at the incoming operation so its results can be latched at
    // acceptance; afterwards it only sees the latched operands.
    assign a_op  = (state_q == LSU_IDLE) ? alucode : alucode_q;
    assign a_off = (state_q == LSU_IDLE) ? addr[1:0] : off_q;

    lsu_align u_align (
        .alucode   (a_op),
        .off       (a_off),
        .wdata     (wdata),
        .mem_rdata (mem_rdata),
        .mem_we    (a_we),
        .wdata_rep (a_wdata),
        .load_data (a_load),
        .misalign  (a_mis)
    );

`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_hit;

    // Cycles spent in REQ/WAIT since the operation was accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if ((state_q == LSU_REQ) || (state_q == LSU_WAIT)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit = ((state_q == LSU_REQ) || (state_q == LSU_WAIT)) &&
                         ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));
    // A genuine grant/return in the final cycle still wins over the abort.
    assign abort = timeout_hit &&
                   (((state_q == LSU_REQ) && !mem_gnt) || ((state_q == LSU_WAIT) && !mem_rvalid));
`else
    assign abort = 1'b0;
`endif

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: illegal or non-memory ops complete straight away without touching memory.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    if (!is_mem_op(alucode) || a_mis) state_d = LSU_DONE;
                    else                              state_d = LSU_REQ;
                end
            end
            LSU_REQ: begin
                if (mem_gnt)    state_d = is_load(alucode_q) ? LSU_WAIT : LSU_DONE;
                else if (abort) state_d = LSU_DONE;
            end
            LSU_WAIT: begin
                if (mem_rvalid || abort) state_d = LSU_DONE;
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // Handshake outputs decoded from state only.
    always_comb begin
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            LSU_IDLE: req_ready  = 1'b1;
            LSU_REQ:  mem_req    = 1'b1;
            LSU_DONE: resp_valid = 1'b1;
            default: begin
                req_ready  = 1'b0;
                mem_req    = 1'b0;
                resp_valid = 1'b0;
            end
        endcase
    end

    // Operand capture at acceptance, load result capture on rvalid, error/zero on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alucode_q <= 6'h0;
            off_q     <= 2'b00;
            addr_q    <= 30'h0;
            we_q      <= 4'b0000;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else if (accept) begin
            alucode_q <= alucode;
            off_q     <= addr[1:0];
            addr_q    <= addr[31:2];
            we_q      <= a_we;
            wdata_q   <= a_wdata;
            rdata_q   <= 32'h0;
            err_q     <= is_mem_op(alucode) && a_mis;
        end else if ((state_q == LSU_WAIT) && mem_rvalid) begin
            rdata_q   <= a_load;
        end else if (abort) begin
            rdata_q   <= 32'h0;
            err_q     <= 1'b1;
        end
    end

    assign mem_addr   = {addr_q, 2'b00};
    assign mem_we     = we_q & {4{mem_req}};
    assign mem_wdata  = wdata_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
